// File: rtl/multiport_ram_clr.sv
// multiport_ram_clr: multi-read-port RAM with byte-enable write, write-first reads and a self-clearing sweep
module multiport_ram_clr #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NUM_RD = 2,
  parameter int BYTE_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr_start,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic [DATA_W/BYTE_W-1:0] be,
  input  logic [DATA_W-1:0]        DI,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] addr,
  output logic [NUM_RD*DATA_W-1:0] DO,
  output logic [NUM_RD-1:0]        DO_valid
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] wmask;
  logic [NUM_RD*DATA_W-1:0] do_q, do_d;
  logic [NUM_RD-1:0] vld_q, vld_d;
  logic wr_en;
  logic [NUM_RD-1:0] rd_en;
  assign busy = state_q == CLEAR;
  assign wr_en = !busy && we;
  assign rd_en = busy ? '0 : re;
  assign vld_d = rd_en;
  assign DO = do_q;
  assign DO_valid = vld_q;
  for (genvar k = 0; k < DATA_W/BYTE_W; k++) begin : g_mask
    assign wmask[k*BYTE_W +: BYTE_W] = {BYTE_W{be[k]}};
  end
  // Each read port sees the merged word when it hits the address being written this cycle.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] old;
    assign a = addr[i*ADDR_W +: ADDR_W];
    assign old = mem_q[a];
    assign do_d[i*DATA_W +: DATA_W] = !rd_en[i] ? do_q[i*DATA_W +: DATA_W] :
                                      (wr_en && write_addr == a) ? (old & ~wmask) | (DI & wmask) : old;
  end
  // Clear sweep advances one word per cycle and returns to IDLE after the last address.
  always_comb begin
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    if (busy) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      state_d = &clr_ptr_q ? IDLE : CLEAR;
    end else if (clr_start) begin
      state_d = CLEAR;
      clr_ptr_d = '0;
    end
  end
  // Sequencer state and registered read outputs; reset restarts the sweep from address 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      do_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      do_q <= do_d;
      vld_q <= vld_d;
    end
  end
  // Array storage: the sweep zeroes one word, otherwise enabled byte lanes take the user write.
  always_ff @(posedge CLK) begin
    if (!RST && busy) mem_q[clr_ptr_q] <= '0;
    else if (!RST && wr_en) mem_q[write_addr] <= (mem_q[write_addr] & ~wmask) | (DI & wmask);
  end
endmodule

// File: tb/tb_multiport_ram_clr.sv
// tb_multiport_ram_clr: directed self-checking bench for multiport_ram_clr
module tb_multiport_ram_clr;
  logic CLK = 1'b0;
  logic RST, clr_start, busy, we;
  logic [5:0] write_addr;
  logic [1:0] be;
  logic [15:0] DI;
  logic [1:0] re;
  logic [11:0] addr;
  logic [31:0] DO;
  logic [1:0] DO_valid;
  int errors = 0;
  int checks = 0;
  int cnt;

  multiport_ram_clr dut (
    .CLK(CLK), .RST(RST), .clr_start(clr_start), .busy(busy), .we(we),
    .write_addr(write_addr), .be(be), .DI(DI), .re(re), .addr(addr),
    .DO(DO), .DO_valid(DO_valid)
  );

  always #5 CLK = ~CLK;

  task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1'b1; write_addr = a; DI = d; be = b;
    @(negedge CLK);
    we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a0, input logic [5:0] a1, input logic [1:0] r);
    re = r; addr = {a1, a0};
    @(negedge CLK);
    re = 2'b00;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_out: DO=%h valid=%b expected 0/00", DO, DO_valid);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge CLK);
    end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL reset_busy_len: got %0d expected 64", cnt);
    end
    rd(6'd0, 6'd37, 2'b11);
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL reset_rd_0_37: DO=%h valid=%b expected 00000000/11", DO, DO_valid);
    end
    rd(6'd63, 6'd63, 2'b11);
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL reset_rd_63: DO=%h valid=%b expected 00000000/11", DO, DO_valid);
    end
  endtask

  task automatic test_byte_en;
    wr(6'd5, 16'hA5C3, 2'b11);
    wr(6'd5, 16'hFF11, 2'b01);
    rd(6'd5, 6'd0, 2'b01);
    checks++;
    if (DO[15:0] !== 16'hA511 || DO_valid !== 2'b01) begin
      errors++;
      $display("FAIL byte_en: DO0=%h valid=%b expected a511/01", DO[15:0], DO_valid);
    end
    wr(6'd5, 16'h0000, 2'b00);
    rd(6'd5, 6'd5, 2'b10);
    checks++;
    if (DO[31:16] !== 16'hA511 || DO_valid !== 2'b10) begin
      errors++;
      $display("FAIL be_zero_noop: DO1=%h valid=%b expected a511/10", DO[31:16], DO_valid);
    end
  endtask

  task automatic test_bypass;
    wr(6'd9, 16'h1234, 2'b11);
    we = 1'b1; write_addr = 6'd9; be = 2'b10; DI = 16'hBEEF; re = 2'b11; addr = {6'd9, 6'd9};
    @(negedge CLK);
    we = 1'b0; re = 2'b00;
    checks++;
    if (DO !== {16'hBE34, 16'hBE34} || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL bypass: DO=%h valid=%b expected be34be34/11", DO, DO_valid);
    end
    rd(6'd9, 6'd0, 2'b01);
    checks++;
    if (DO[15:0] !== 16'hBE34) begin
      errors++;
      $display("FAIL bypass_stored: DO0=%h expected be34", DO[15:0]);
    end
  endtask

  task automatic test_ports;
    wr(6'd3, 16'h0003, 2'b11);
    wr(6'd4, 16'h0004, 2'b11);
    rd(6'd3, 6'd4, 2'b11);
    checks++;
    if (DO !== 32'h0004_0003 || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL ports: DO=%h valid=%b expected 00040003/11", DO, DO_valid);
    end
    addr = {6'd9, 6'd9};
    @(negedge CLK);
    checks++;
    if (DO !== 32'h0004_0003 || DO_valid !== 2'b00) begin
      errors++;
      $display("FAIL hold: DO=%h valid=%b expected 00040003/00", DO, DO_valid);
    end
    rd(6'd9, 6'd9, 2'b10);
    checks++;
    if (DO !== 32'hBE34_0003 || DO_valid !== 2'b10) begin
      errors++;
      $display("FAIL port1_only: DO=%h valid=%b expected be340003/10", DO, DO_valid);
    end
  endtask

  task automatic test_clear_req;
    wr(6'd20, 16'h7777, 2'b11);
    rd(6'd20, 6'd20, 2'b11);
    checks++;
    if (DO !== 32'h7777_7777) begin
      errors++;
      $display("FAIL pre_clear: DO=%h expected 77777777", DO);
    end
    clr_start = 1'b1;
    @(negedge CLK);
    clr_start = 1'b0;
    write_addr = 6'd21; DI = 16'h5555; be = 2'b11; addr = {6'd3, 6'd3};
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      we = (cnt == 50);
      clr_start = (cnt == 30 || cnt == 64);
      re = (cnt == 40) ? 2'b11 : 2'b00;
      @(negedge CLK);
      if (cnt == 40) begin
        checks++;
        if (DO_valid !== 2'b00 || DO !== 32'h7777_7777) begin
          errors++;
          $display("FAIL read_while_busy: DO=%h valid=%b expected 77777777/00", DO, DO_valid);
        end
      end
    end
    we = 1'b0; clr_start = 1'b0; re = 2'b00;
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL clear_busy_len: got %0d expected 64", cnt);
    end
    rd(6'd20, 6'd21, 2'b11);
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL cleared_20_21: DO=%h valid=%b expected 00000000/11", DO, DO_valid);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_restart: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    wr(6'd7, 16'hABCD, 2'b11);
    rd(6'd7, 6'd7, 2'b11);
    checks++;
    if (DO !== 32'hABCD_ABCD) begin
      errors++;
      $display("FAIL pre_mid: DO=%h expected abcdabcd", DO);
    end
    clr_start = 1'b1;
    @(negedge CLK);
    clr_start = 1'b0;
    repeat (29) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_out: DO=%h valid=%b busy=%b expected 0/00/1", DO, DO_valid, busy);
    end
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge CLK);
    end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL mid_busy_len: got %0d expected 64", cnt);
    end
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_after: DO=%h valid=%b expected 0/00", DO, DO_valid);
    end
    rd(6'd7, 6'd63, 2'b11);
    checks++;
    if (DO !== 32'h0 || DO_valid !== 2'b11) begin
      errors++;
      $display("FAIL mid_cleared: DO=%h valid=%b expected 00000000/11", DO, DO_valid);
    end
  endtask

  initial begin
    RST = 1'b1; clr_start = 1'b0; we = 1'b0; write_addr = '0; be = '0; DI = '0; re = '0; addr = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (70) @(negedge CLK);
    test_reset;
    test_byte_en;
    test_bypass;
    test_ports;
    test_clear_req;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
